// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data port.
// Takes one request at a time over valid/ready. Byte-masked writes are
// committed at the acceptance edge. A registered word response follows after
// WAIT_CYC wait states. Out-of-range word indices return resp_err=1 and
// resp_rdata=0, and they leave the array untouched.
// Optional build macro: DMEM_STATS_EN adds read/write/error response counters.
module dmem_responder #(
   parameter int          ADDR_W   = 12,
   parameter int unsigned DEPTH    = 1024,
   parameter int          WAIT_CYC = 0
) (
   input  logic              CLK100MHZ,
   input  logic              nrst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_wmask,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]       stat_rd_cnt,
   output logic [15:0]       stat_wr_cnt,
   output logic [15:0]       stat_err_cnt
`endif
);

   localparam int IDX_W  = ADDR_W - 2;
   localparam int MEM_AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [IDX_W-1:0]  lat_idx;
   logic              lat_err;
   logic [31:0]       mem [DEPTH];

   logic [IDX_W-1:0]  req_idx;
   logic              req_oor;
   logic              accept;

   // Replace the enabled byte lanes of a word with the lane-aligned store data
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [3:0]  mask);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            merged[8*i +: 8] = data[8*i +: 8];
         end
      end
      return merged;
   endfunction

   // A word index at or beyond DEPTH has no backing storage
   function automatic logic out_of_range(input logic [IDX_W-1:0] idx);
      return 32'(idx) >= DEPTH;
   endfunction

   // Narrow or widen a word index to the array address width (only used when in range)
   function automatic logic [MEM_AW-1:0] mem_index(input logic [IDX_W-1:0] idx);
      return MEM_AW'(idx);
   endfunction

   assign req_idx = req_addr[ADDR_W-1:2];
   assign req_oor = out_of_range(req_idx);
   assign accept  = nrst & req_ready & req_valid;

   // Commit byte-lane writes at the acceptance edge; storage is never reset
   always_ff @(posedge CLK100MHZ) begin
      if (accept && !req_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (req_wmask[i]) begin
               mem[mem_index(req_idx)][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Request FSM: accept, optionally wait, then pulse a registered response
   always_ff @(posedge CLK100MHZ) begin
      if (!nrst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         lat_idx    <= '0;
         lat_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  req_ready <= 1'b0;
                  lat_idx   <= req_idx;
                  lat_err   <= req_oor;
                  if (WAIT_CYC == 0) begin
                     // No wait states: the response word must already include this write
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= req_oor;
                     resp_rdata <= req_oor ? 32'h0
                                           : merge_bytes(mem[mem_index(req_idx)], req_wdata, req_wmask);
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= 4'd1;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'(WAIT_CYC)) begin
                  // The write was committed at acceptance, so the array already holds it
                  state      <= RESP;
                  wait_cnt   <= 4'd0;
                  resp_valid <= 1'b1;
                  resp_err   <= lat_err;
                  resp_rdata <= lat_err ? 32'h0 : mem[mem_index(lat_idx)];
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
            default: begin
               state      <= IDLE;
               wait_cnt   <= 4'd0;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
         endcase
      end
   end

`ifdef DMEM_STATS_EN
   logic lat_write;

   // Count completed responses by kind; errors are counted only as errors
   always_ff @(posedge CLK100MHZ) begin
      if (!nrst) begin
         lat_write    <= 1'b0;
         stat_rd_cnt  <= 16'h0;
         stat_wr_cnt  <= 16'h0;
         stat_err_cnt <= 16'h0;
      end else begin
         if (accept) begin
            lat_write <= |req_wmask;
         end
         if (state == RESP) begin
            if (lat_err) begin
               stat_err_cnt <= stat_err_cnt + 16'd1;
            end else if (lat_write) begin
               stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end else begin
               stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Instance 0 uses the default configuration, with no
// wait states. Instance 1 uses 14-bit addresses and three wait states, so it can
// reach out-of-range addresses. A word-array reference model predicts each
// response from the addressing and byte-lane rules.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        nrst;
   logic        rv [2];
   logic        rr [2];
   logic [13:0] ra [2];
   logic [3:0]  rm [2];
   logic [31:0] rd [2];
   logic        pv [2];
   logic [31:0] pd [2];
   logic        pe [2];
`ifdef DMEM_STATS_EN
   logic [15:0] st_rd [2];
   logic [15:0] st_wr [2];
   logic [15:0] st_er [2];
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [2][1024];
   int exp_rd [2];
   int exp_wr [2];
   int exp_er [2];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(12), .DEPTH(1024), .WAIT_CYC(0)) u_a (
      .CLK100MHZ(clk), .nrst(nrst), .req_valid(rv[0]), .req_ready(rr[0]),
      .req_addr(ra[0][11:0]), .req_wmask(rm[0]), .req_wdata(rd[0]),
      .resp_valid(pv[0]), .resp_rdata(pd[0]), .resp_err(pe[0])
`ifdef DMEM_STATS_EN
      , .stat_rd_cnt(st_rd[0]), .stat_wr_cnt(st_wr[0]), .stat_err_cnt(st_er[0])
`endif
   );

   dmem_responder #(.ADDR_W(14), .DEPTH(1024), .WAIT_CYC(3)) u_b (
      .CLK100MHZ(clk), .nrst(nrst), .req_valid(rv[1]), .req_ready(rr[1]),
      .req_addr(ra[1]), .req_wmask(rm[1]), .req_wdata(rd[1]),
      .resp_valid(pv[1]), .resp_rdata(pd[1]), .resp_err(pe[1])
`ifdef DMEM_STATS_EN
      , .stat_rd_cnt(st_rd[1]), .stat_wr_cnt(st_wr[1]), .stat_err_cnt(st_er[1])
`endif
   );

   function automatic int wcyc(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: apply one request, return the expected response
   task automatic model(input int d, input logic [13:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, output logic [31:0] ew, output logic ee);
      int idx;
      idx = int'(addr) / 4;
      if (idx >= 1024) begin
         ee = 1'b1;
         ew = 32'h0;
         exp_er[d]++;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (mask[i]) mdl[d][idx][8*i +: 8] = data[8*i +: 8];
         end
         ee = 1'b0;
         ew = mdl[d][idx];
         if (mask != 4'b0000) exp_wr[d]++;
         else exp_rd[d]++;
      end
   endtask

   // One complete request: handshake, latency, data, error and pulse width
   task automatic do_req(input int d, input logic [13:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input string tag);
      int n;
      bit got;
      logic [31:0] ew;
      logic ee;
      @(negedge clk);
      rv[d] = 1'b1; ra[d] = addr; rm[d] = mask; rd[d] = data;
      n = 0;
      while (rr[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(rr[d]), 32'd1);
      model(d, addr, mask, data, ew, ee);
      @(posedge clk);
      #1 rv[d] = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (pv[d] === 1'b1) got = 1'b1;
      end
      chk({tag, "_latency"}, 32'(n), 32'(1 + wcyc(d)));
      chk({tag, "_rdata"}, pd[d], ew);
      chk({tag, "_err"}, 32'(pe[d]), 32'(ee));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(pv[d]), 32'd0);
   endtask

   initial begin
      logic [13:0] a;
      logic [3:0]  m;
      logic [31:0] w;
      nrst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rv[d] = 1'b0; ra[d] = 14'h0; rm[d] = 4'h0; rd[d] = 32'h0;
         exp_rd[d] = 0; exp_wr[d] = 0; exp_er[d] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", 32'(rr[d]), 32'd1);
         chk("rst_valid", 32'(pv[d]), 32'd0);
         chk("rst_rdata", pd[d], 32'h0);
         chk("rst_err", 32'(pe[d]), 32'd0);
      end
      nrst = 1'b1;

      // Full-word write then read, zero wait states
      do_req(0, 14'h010, 4'b1111, 32'hDEADBEEF, "t1_wr");
      do_req(0, 14'h010, 4'b0000, 32'h0, "t1_rd");

      // Single-lane write and sub-word address aliasing
      do_req(0, 14'h020, 4'b1111, 32'h11223344, "t2_pre");
      do_req(0, 14'h020, 4'b0100, 32'h00AA0000, "t2_wr");
      do_req(0, 14'h020, 4'b0000, 32'h0, "t2_rd");
      do_req(0, 14'h022, 4'b0000, 32'h0, "t2_rd22");
      chk("t2_model", mdl[0][8], 32'h11AA3344);

      // Wait-state timing with req_valid held across two transactions
      do_req(1, 14'h010, 4'b1111, 32'h5A5A1234, "t3_pre");
      @(negedge clk);
      rv[1] = 1'b1; ra[1] = 14'h010; rm[1] = 4'b0000; rd[1] = 32'h0;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         chk("t3_ready", 32'(rr[1]), 32'(c == 5 || c == 10));
         chk("t3_valid", 32'(pv[1]), 32'(c == 4 || c == 9));
         if (c == 4 || c == 9) chk("t3_rdata", pd[1], 32'h5A5A1234);
         if (c == 10) rv[1] = 1'b0;
      end
      exp_rd[1] += 2;

      // Out-of-range write leaves word 0 alone
      do_req(1, 14'h0000, 4'b1111, 32'h0BADC0DE, "t4_pre");
      do_req(1, 14'h1000, 4'b1111, 32'h12345678, "t4_oor");
      do_req(1, 14'h0000, 4'b0000, 32'h0, "t4_rd0");

      // Randomized mix over a preloaded pool of words
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 16; k++) begin
            do_req(d, 14'(256 + 4 * k), 4'b1111, $urandom, "rnd_pre");
         end
         for (int k = 0; k < 30; k++) begin
            a = 14'(256 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
            m = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            w = $urandom;
            if (d == 1 && $urandom_range(0, 7) == 0) a = 14'($urandom_range(4096, 16383));
            do_req(d, a, m, w, "rnd");
         end
      end

`ifdef DMEM_STATS_EN
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("stat_rd", 32'(st_rd[d]), 32'(exp_rd[d] % 65536));
         chk("stat_wr", 32'(st_wr[d]), 32'(exp_wr[d] % 65536));
         chk("stat_err", 32'(st_er[d]), 32'(exp_er[d] % 65536));
      end
`endif

      // Reset during WAIT aborts the response but keeps the committed write
      @(negedge clk);
      rv[1] = 1'b1; ra[1] = 14'h040; rm[1] = 4'b1111; rd[1] = 32'hCAFEF00D;
      chk("t5_ready", 32'(rr[1]), 32'd1);
      mdl[1][16] = 32'hCAFEF00D;
      @(posedge clk);
      #1 rv[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(posedge clk);
      #1 nrst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         exp_rd[d] = 0; exp_wr[d] = 0; exp_er[d] = 0;
      end
`ifdef DMEM_STATS_EN
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("stat_rst_rd", 32'(st_rd[d]), 32'd0);
         chk("stat_rst_wr", 32'(st_wr[d]), 32'd0);
         chk("stat_rst_err", 32'(st_er[d]), 32'd0);
      end
`endif
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("t5_novalid", 32'(pv[1]), 32'd0);
         chk("t5_ready_after", 32'(rr[1]), 32'd1);
      end
      do_req(1, 14'h040, 4'b0000, 32'h0, "t5_rd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
